// File: rtl/ode_mem_pkg.sv
// ode_mem_pkg: shared types and solver memory map for the data-memory arbiter
package ode_mem_pkg;
  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, LOCKED} state_e;
  localparam logic [63:0] H_ADDR  = 64'h00;
  localparam logic [63:0] X0_ADDR = 64'h08;
  localparam logic [63:0] X1_ADDR = 64'h10;
  localparam logic [63:0] T_ADDR  = 64'h18;
  localparam logic [63:0] N_ADDR  = 64'h20;
  localparam logic [63:0] L_ADDR  = 64'h28;
endpackage

// File: rtl/ode_mem_arbiter_if.sv
// ode_mem_arbiter_if: requester bus plus memory-macro side of the arbiter
interface ode_mem_arbiter_if
  import ode_mem_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
);
  logic [NUM_REQ-1:0]        req, we, lock, gnt, rvalid;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [DATA_W-1:0]         rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      busy, mem_en, mem_we;
  modport slave (
    input  req, we, lock, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output req, we, lock, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ode_mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester at or after ptr
module rr_pick #(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] win_o,
  output logic          valid_o
);
  logic [2*N-1:0] dbl;
  always_comb begin
    dbl = {req_i, req_i} >> ptr_i;
    win_o = '0;
    valid_o = 1'b0;
    // descending scan so the nearest requester to ptr is written last
    for (int i = N - 1; i >= 0; i--)
      if (dbl[i]) begin
        valid_o = 1'b1;
        win_o = IW'((int'(ptr_i) + i) % N);
      end
  end
endmodule

// File: rtl/ode_mem_arbiter.sv
// ode_mem_arbiter: round-robin single-beat access to the solver data memory with owner lock
module ode_mem_arbiter
  import ode_mem_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_LAT   = 2,
  parameter int LOCK_MAX = 64
) (
  input logic clk,
  input logic reset,
  ode_mem_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam int RW = $clog2(RD_LAT + 1);
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, w_q, w_d, pick_w, cap_w;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic we_q, we_d, lk_q, lk_d, pick_v, lock_go, cap, done, keep;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i  (bus.req),
    .ptr_i  (ptr_q),
    .win_o  (pick_w),
    .valid_o(pick_v)
  );
  assign lock_go = bus.req[owner_q] && int'(lock_cnt_q) < LOCK_MAX;
  assign cap     = (state_q == IDLE && pick_v) || (state_q == LOCKED && lock_go);
  assign cap_w   = (state_q == LOCKED) ? owner_q : pick_w;
  assign done    = (state_q == ISSUE && we_q) || (state_q == RD_WAIT && cnt_q == RW'(1));
  assign keep    = lk_q && (int'(lock_cnt_q) + 1 < LOCK_MAX);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    lock_cnt_d = lock_cnt_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    rvalid_d = '0;
    w_d = cap ? cap_w : w_q;
    we_d = cap ? bus.we[cap_w] : we_q;
    lk_d = cap ? bus.lock[cap_w] : lk_q;
    addr_d = cap ? bus.addr[cap_w*ADDR_W +: ADDR_W] : addr_q;
    wdata_d = cap ? bus.wdata[cap_w*DATA_W +: DATA_W] : wdata_q;
    case (state_q)
      IDLE: state_d = pick_v ? ISSUE : IDLE;
      ISSUE: begin
        ptr_d = IW'((int'(w_q) + 1) % NUM_REQ);
        cnt_d = RW'(RD_LAT);
        state_d = we_q ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        rdata_d = (cnt_q == RW'(1)) ? bus.mem_rdata : rdata_q;
        rvalid_d = (cnt_q == RW'(1)) ? NUM_REQ'(1) << w_q : '0;
      end
      LOCKED: begin
        state_d = lock_go ? ISSUE : IDLE;
        owner_d = lock_go ? owner_q : '0;
        lock_cnt_d = lock_go ? lock_cnt_q : '0;
      end
      default: state_d = IDLE;
    endcase
    // a finished write or read either keeps the lock or hands the memory back
    if (done) begin
      state_d = keep ? LOCKED : IDLE;
      owner_d = keep ? w_q : '0;
      lock_cnt_d = keep ? lock_cnt_q + 1'b1 : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      lock_cnt_q <= '0;
      cnt_q <= '0;
      w_q <= '0;
      we_q <= 1'b0;
      lk_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rvalid_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      cnt_q <= cnt_d;
      w_q <= w_d;
      we_q <= we_d;
      lk_q <= lk_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end
  assign bus.gnt       = (state_q == ISSUE) ? NUM_REQ'(1) << w_q : '0;
  assign bus.mem_en    = state_q == ISSUE;
  assign bus.mem_we    = state_q == ISSUE && we_q;
  assign bus.mem_addr  = (state_q == ISSUE) ? addr_q : '0;
  assign bus.mem_wdata = (state_q == ISSUE) ? wdata_q : '0;
  assign bus.busy      = state_q != IDLE;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
endmodule
